ctrl_pipe: RTL and testbench

- Control-signal pipeline for the 5-stage RISC-V core.
- Consumes the Decode-stage outputs of the main/ALU decoder and carries them through the Execute, Memory and Writeback pipeline registers.
- Resolves the branch/jump decision in Execute and exposes the per-stage destination-register and write-enable taps used by the hazard unit.
- Counts retired instructions.

---
 rtl/ctrl_pipe.sv | 92 +++++++++
 tb/tb_ctrl_pipe.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decode-to-writeback control pipeline with branch resolution and retire counter
module ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [4:0]       RdD,
  input  logic             FlushE,
  input  logic             ZeroE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic             PCSrcE,
  output logic             ResultSrcE0,
  output logic [4:0]       RdE,
  output logic [4:0]       RdM,
  output logic [4:0]       RdW,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcW,
  output logic [CNT_W-1:0] retired
);
  logic       ValidE, RegWriteE, MemWriteE, JumpE, BranchE;
  logic [1:0] ResultSrcE, ResultSrcM;
  logic       ValidM, ValidW;
  // Execute register: a flushed or invalid decode slot loads an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset || !ValidD || FlushE) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 3'b000;
      RdE         <= 5'd0;
    end else begin
      ValidE      <= 1'b1;
      RegWriteE   <= RegWriteD;
      ResultSrcE  <= ResultSrcD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ALUControlE <= ALUControlD;
      RdE         <= RdD;
    end
  end
  // Memory and writeback registers copy the previous stage every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      RdM        <= 5'd0;
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
    end else begin
      ValidM     <= ValidE;
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      RdM        <= RdE;
      ValidW     <= ValidM;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
    end
  end
  // Count instructions leaving writeback; wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) retired <= '0;
    else if (ValidW) retired <= retired + CNT_W'(1);
  end
  // Branch/jump resolution and load-use tap from Execute state only
  always_comb begin
    PCSrcE      = (BranchE & ZeroE) | JumpE;
    ResultSrcE0 = ResultSrcE[0];
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed table, corner sequences and randomized model check of ctrl_pipe
module tb_ctrl_pipe;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ValidD = 0, RegWriteD = 0, MemWriteD = 0, JumpD = 0, BranchD = 0, ALUSrcD = 0;
  logic [1:0]    ResultSrcD = 0;
  logic [2:0]    ALUControlD = 0;
  logic [4:0]    RdD = 0;
  logic          FlushE = 0, ZeroE = 0;
  logic [2:0]    ALUControlE;
  logic          ALUSrcE, PCSrcE, ResultSrcE0, RegWriteM, RegWriteW, MemWriteM;
  logic [4:0]    RdE, RdM, RdW;
  logic [1:0]    ResultSrcW;
  logic [CW-1:0] retired;
  logic [29:0]   act;
  int            vectors = 0, miscompares = 0;

  ctrl_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .RdD(RdD), .FlushE(FlushE), .ZeroE(ZeroE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemWriteM(MemWriteM), .ResultSrcW(ResultSrcW), .retired(retired)
  );

  always #5 clk = ~clk;

  assign act = {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0, RdE, RdM, RdW,
                RegWriteM, RegWriteW, MemWriteM, ResultSrcW, retired};

  typedef struct packed {
    logic       v, rw;
    logic [1:0] rs;
    logic       mw, j, b, as;
    logic [2:0] ac;
    logic [4:0] rd;
  } ins_t;

  typedef struct {
    logic [15:0] d;
    logic        fl, z;
    logic [29:0] e;
  } vec_t;

  ins_t          hist[$];
  logic [CW-1:0] mret = '0;
  vec_t          tab[13];

  function automatic logic [15:0] din(logic v, logic rw, logic [1:0] rs, logic mw, logic j,
                                      logic b, logic as, logic [2:0] ac, logic [4:0] rd);
    return {v, rw, rs, mw, j, b, as, ac, rd};
  endfunction

  function automatic logic [29:0] dexp(logic [2:0] ac, logic as, logic pc, logic rs0,
                                       logic [4:0] rde, logic [4:0] rdm, logic [4:0] rdw,
                                       logic rwm, logic rww, logic mwm, logic [1:0] rsw,
                                       logic [CW-1:0] ret);
    return {ac, as, pc, rs0, rde, rdm, rdw, rwm, rww, mwm, rsw, ret};
  endfunction

  function automatic logic [29:0] model_out();
    ins_t e, m, w;
    e = hist.size() > 0 ? hist[0] : '0;
    m = hist.size() > 1 ? hist[1] : '0;
    w = hist.size() > 2 ? hist[2] : '0;
    return {e.ac, e.as, (e.b & ZeroE) | e.j, e.rs[0], e.rd, m.rd, w.rd,
            m.rw, w.rw, m.mw, w.rs, mret};
  endfunction

  task automatic check(input string nm, input logic [29:0] a, input logic [29:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick(input logic [15:0] d, input logic fl, input logic rst, input logic z);
    ins_t r, old;
    {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD, RdD} = d;
    FlushE = fl;
    reset = rst;
    @(posedge clk);
    r = (d[15] && !fl) ? ins_t'(d) : '0;
    if (rst) begin
      hist.delete();
      mret = '0;
    end else begin
      hist.push_front(r);
      if (hist.size() > 3) begin
        old = hist.pop_back();
        if (old.v) mret = mret + 1'b1;
      end
    end
    #1 ZeroE = z;
    #1;
  endtask

  initial begin
    logic [CW-1:0] start;
    tab[0]  = '{din(1,1,2'b01,0,0,0,1,3'd0,5'd5), 0, 0, dexp(0,1,0,1,5,0,0,0,0,0,2'b00,0)};
    tab[1]  = '{din(0,0,2'b00,0,0,0,0,3'd0,5'd0), 0, 0, dexp(0,0,0,0,0,5,0,1,0,0,2'b00,0)};
    tab[2]  = '{din(1,0,2'b00,0,0,1,0,3'd1,5'd0), 0, 1, dexp(1,0,1,0,0,0,5,0,1,0,2'b01,0)};
    tab[3]  = '{din(1,1,2'b10,0,1,0,0,3'd0,5'd1), 0, 0, dexp(0,0,1,0,1,0,0,0,0,0,2'b00,1)};
    tab[4]  = '{din(1,0,2'b00,1,0,0,1,3'd0,5'd7), 1, 1, dexp(0,0,0,0,0,1,0,1,0,0,2'b00,1)};
    tab[5]  = '{din(1,0,2'b00,1,0,0,1,3'd0,5'd0), 0, 0, dexp(0,1,0,0,0,0,1,0,1,0,2'b10,2)};
    tab[6]  = '{din(1,0,2'b00,0,0,1,0,3'd1,5'd0), 0, 0, dexp(1,0,0,0,0,0,0,0,0,1,2'b00,3)};
    tab[7]  = '{din(0,0,2'b00,0,0,0,0,3'd0,5'd0), 1, 1, dexp(0,0,0,0,0,0,0,0,0,0,2'b00,3)};
    tab[8]  = '{din(1,1,2'b00,0,0,0,0,3'd0,5'd10), 0, 1, dexp(0,0,0,0,10,0,0,0,0,0,2'b00,4)};
    tab[9]  = '{din(0,0,2'b00,0,0,0,0,3'd0,5'd0), 0, 0, dexp(0,0,0,0,0,10,0,1,0,0,2'b00,5)};
    tab[10] = '{din(0,0,2'b00,0,0,0,0,3'd0,5'd0), 0, 0, dexp(0,0,0,0,0,0,10,0,1,0,2'b00,5)};
    tab[11] = '{din(0,0,2'b00,0,0,0,0,3'd0,5'd0), 0, 0, dexp(0,0,0,0,0,0,0,0,0,0,2'b00,6)};
    tab[12] = '{din(0,0,2'b00,0,0,0,0,3'd0,5'd0), 0, 0, dexp(0,0,0,0,0,0,0,0,0,0,2'b00,6)};
    for (int i = 0; i < 2; i++) begin
      tick(16'($urandom), 1'($urandom), 1, 1'b1);
      check("reset_state", act, 30'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(16'($urandom) & 16'h7fff, 0, 0, 1'($urandom));
      check("idle_after_reset", act, 30'h0);
    end
    for (int i = 0; i < 13; i++) begin
      tick(tab[i].d, tab[i].fl, 0, tab[i].z);
      check($sformatf("table_vec%0d", i), act, tab[i].e);
    end
    start = retired;
    for (int i = 0; i < 19; i++) begin
      tick(din(1,1,2'b00,0,0,0,0,3'(i),5'(i)), 0, 0, 1'($urandom));
      check("wrap_model", act, model_out());
    end
    check("wrap_retired", {26'b0, retired}, {26'b0, start});
    tick(din(1,1,2'b10,0,1,0,0,3'd0,5'd1), 0, 0, 1);
    tick(din(1,1,2'b01,0,0,0,1,3'd0,5'd6), 0, 0, 1);
    tick(din(1,0,2'b00,1,0,0,1,3'd0,5'd0), 0, 0, 1);
    tick(din(1,1,2'b10,0,1,0,0,3'd0,5'd1), 0, 1, 1);
    check("midstream_reset", act, 30'h0);
    tick(din(1,1,2'b10,0,1,0,0,3'd0,5'd3), 0, 0, 0);
    check("refill_after_reset", act, model_out());
    for (int i = 0; i < 400; i++) begin
      tick(16'($urandom) | ($urandom_range(0, 3) != 0 ? 16'h8000 : 16'h0),
           $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0, 1'($urandom));
      check("random_model", act, model_out());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
